pwm_timer: RTL and testbench

- 16-bit PWM generator / interval timer with a Wishbone-classic slave register interface.
- A prescaler divides the tick source (system clock, or rising edges of i_extclk) by a programmable divisor. A 16-bit counter counts ticks up to a programmed period.
- PWM mode: o_pwm is high while count < duty. Timer mode: terminal count raises an interrupt flag, which drives o_pwm.
- Sits on the peripheral bus; o_pwm goes to a pad.

---
 rtl/pwm_timer_pkg.sv | 24 ++
 rtl/pwm_timer_if.sv | 18 +
 rtl/pwm_timer_prescaler.sv | 45 ++++
 rtl/pwm_timer.sv | 120 ++++++++++++
 tb/tb_pwm_timer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared constants for the PWM / interval timer: register map, ctrl bit positions, default widths.
package pwm_timer_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  // word addresses
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_DIV    = 1;
  localparam int ADDR_PERIOD = 2;
  localparam int ADDR_DC     = 3;

  // ctrl bit positions
  localparam int CTRL_CLK_SEL = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_EN      = 2;
  localparam int CTRL_CONT    = 3;
  localparam int CTRL_OUT_EN  = 4;
  localparam int CTRL_IRQ     = 5;
  localparam int CTRL_EXT_DC  = 6;
  localparam int CTRL_CNT_RST = 7;
  localparam int CTRL_W       = 8;

endpackage

// File: rtl/pwm_timer_if.sv
// Wishbone-classic register bus between a master and the timer.
interface pwm_timer_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_adr;
  logic [DW-1:0] i_wb_data;
  logic          o_wb_ack;
  logic [DW-1:0] o_wb_data;

  modport master (output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
                  input  o_wb_ack, o_wb_data);
  modport slave  (input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
                  output o_wb_ack, o_wb_data);
endinterface

// File: rtl/pwm_timer_prescaler.sv
// Tick source select (system clock or synchronized i_extclk rising edge) and divide-by-N.
module pwm_timer_prescaler #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_extclk,
  input  logic          i_clk_sel,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [DW-1:0] i_div,
  output logic          o_tick
);

  logic [2:0]    sync_q, sync_d;
  logic [DW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] div_eff;
  logic          ev, wrap;

  // two-flop synchronizer plus one delay stage for rising-edge detect
  always_comb sync_d = {sync_q[1:0], i_extclk};

  // divide counter; >= so shrinking the divisor mid-count cannot run away
  always_comb begin
    div_eff = (i_div == '0) ? DW'(1) : i_div;
    ev      = i_clk_sel ? (sync_q[1] & ~sync_q[2]) : 1'b1;
    wrap    = pcnt_q >= (div_eff - DW'(1));
    o_tick  = ~i_clr & i_en & ev & wrap;
    pcnt_d  = pcnt_q;
    if (i_clr)          pcnt_d = '0;
    else if (i_en & ev) pcnt_d = wrap ? '0 : pcnt_q + DW'(1);
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
      pcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// 16-bit PWM generator / interval timer with a Wishbone-classic register slave.
module pwm_timer
  import pwm_timer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pwm_timer_if.slave    wb,
  input  logic          i_extclk,
  input  logic [DW-1:0] i_DC,
  input  logic          i_DC_valid,
  output logic          o_pwm
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0]     div_q, div_d, period_q, period_d, dc_q, dc_d;
  logic [DW-1:0]     ext_q, ext_d, count_q, count_d, rdata_q, rdata_d;
  logic              ack_q, ack_d, pwm_q, pwm_d;

  logic          bus_req, bus_wr;
  logic          sel_ctrl, sel_div, sel_period, sel_dc;
  logic          tick, term;
  logic [DW-1:0] per_eff, duty;

  pwm_timer_prescaler #(.DW(DW)) u_presc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_extclk  (i_extclk),
    .i_clk_sel (ctrl_q[CTRL_CLK_SEL]),
    .i_en      (ctrl_q[CTRL_EN]),
    .i_clr     (ctrl_q[CTRL_CNT_RST]),
    .i_div     (div_q),
    .o_tick    (tick)
  );

  // bus decode: ack one cycle after a fresh request, read data only valid under ack
  always_comb begin
    bus_req    = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    bus_wr     = bus_req & wb.i_wb_we;
    sel_ctrl   = wb.i_wb_adr == AW'(ADDR_CTRL);
    sel_div    = wb.i_wb_adr == AW'(ADDR_DIV);
    sel_period = wb.i_wb_adr == AW'(ADDR_PERIOD);
    sel_dc     = wb.i_wb_adr == AW'(ADDR_DC);
    ack_d      = bus_req;
    rdata_d    = '0;
    if (bus_req) begin
      if (sel_ctrl)        rdata_d = {{(DW-CTRL_W){1'b0}}, ctrl_q};
      else if (sel_div)    rdata_d = div_q;
      else if (sel_period) rdata_d = period_q;
      else if (sel_dc)     rdata_d = dc_q;
    end
  end

  // counter: counter_rst beats a tick; >= lets a shortened period wrap at once
  always_comb begin
    per_eff = (period_q == '0) ? DW'(1) : period_q;
    term    = tick & (count_q >= (per_eff - DW'(1)));
    count_d = count_q;
    if (ctrl_q[CTRL_CNT_RST]) count_d = '0;
    else if (tick)            count_d = term ? '0 : count_q + DW'(1);
  end

  // register writes, then hardware updates so the irq set beats a software clear
  always_comb begin
    div_d    = (bus_wr & sel_div)    ? wb.i_wb_data : div_q;
    period_d = (bus_wr & sel_period) ? wb.i_wb_data : period_q;
    dc_d     = (bus_wr & sel_dc)     ? wb.i_wb_data : dc_q;
    ext_d    = i_DC_valid ? i_DC : ext_q;
    ctrl_d   = ctrl_q;
    ctrl_d[CTRL_CNT_RST] = 1'b0;
    if (bus_wr & sel_ctrl) begin
      ctrl_d           = wb.i_wb_data[CTRL_W-1:0];
      // irq is write-0-to-clear; writing 1 leaves it as is
      ctrl_d[CTRL_IRQ] = ctrl_q[CTRL_IRQ] & wb.i_wb_data[CTRL_IRQ];
    end
    if (term & ~ctrl_q[CTRL_MODE]) begin
      ctrl_d[CTRL_IRQ] = 1'b1;
      if (~ctrl_q[CTRL_CONT]) ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  // output select: PWM compare or timer flag
  always_comb begin
    duty  = ctrl_q[CTRL_EXT_DC] ? ext_q : dc_q;
    pwm_d = ctrl_q[CTRL_OUT_EN] &
            (ctrl_q[CTRL_MODE] ? (ctrl_q[CTRL_EN] & (count_q < duty)) : ctrl_q[CTRL_IRQ]);
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_q   <= '0;
      div_q    <= '0;
      period_q <= '0;
      dc_q     <= '0;
      ext_q    <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      period_q <= period_d;
      dc_q     <= dc_d;
      ext_q    <= ext_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      pwm_q    <= pwm_d;
    end
  end

  assign wb.o_wb_ack  = ack_q;
  assign wb.o_wb_data = rdata_q;
  assign o_pwm        = pwm_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Self-checking bench for pwm_timer: register table, waveform model, timer and ext-clock sequences.
module tb_pwm_timer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_extclk;
  logic [15:0] i_DC = '0;
  logic        i_DC_valid = 1'b0;
  logic        o_pwm;
  bit          ext_run = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  pwm_timer_if #(.AW(4), .DW(16)) wb();

  pwm_timer #(.DW(16), .AW(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .wb         (wb.slave),
    .i_extclk   (i_extclk),
    .i_DC       (i_DC),
    .i_DC_valid (i_DC_valid),
    .o_pwm      (o_pwm)
  );

  always #5 i_clk = ~i_clk;

  // external tick source at i_clk/4 while enabled
  initial begin
    i_extclk = 1'b0;
    forever begin
      repeat (2) @(posedge i_clk);
      #2;
      if (ext_run) i_extclk = ~i_extclk;
    end
  end

  typedef struct {
    logic [3:0]  adr;
    logic [15:0] wd;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // one Wishbone transaction; entered and left 1ns after a rising edge
  task automatic bus(input logic we, input logic [3:0] adr, input logic [15:0] wd,
                     output logic [15:0] rd);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = we;
    wb.i_wb_adr  = adr;
    wb.i_wb_data = wd;
    @(posedge i_clk); #1;
    chk("ack_rise", wb.o_wb_ack, 1);
    rd = wb.o_wb_data;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
    @(posedge i_clk); #1;
    chk("ack_pulse", wb.o_wb_ack, 0);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [15:0] wd);
    logic [15:0] rd;
    bus(1'b1, adr, wd, rd);
  endtask

  // load registers and restart the count (counter_rst is OR'd into ctrl)
  task automatic cfg(input int div, input int per, input int dc, input logic [15:0] ctrl);
    wr(4'd1, 16'(div));
    wr(4'd2, 16'(per));
    wr(4'd3, 16'(dc));
    wr(4'd0, ctrl | 16'h0080);
  endtask

  // compare o_pwm against the ideal waveform: tick index k/div, count = that mod period
  task automatic pwm_window(input string nm, input int div, input int per, input int duty,
                            input bit oe, input int n);
    int d, p, bad, first;
    logic e;
    d = (div == 0) ? 1 : div;
    p = (per == 0) ? 1 : per;
    bad = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      e = oe && (((k / d) % p) < duty);
      if (o_pwm !== e) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    if (bad != 0) $display("  %s: first bad cycle %0d (div=%0d per=%0d duty=%0d)", nm, first, div, per, duty);
    chk(nm, bad, 0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  ackpat;
    int bad, last, ntr;
    logic prev;

    vecs[0] = '{4'd1,  16'h0004, 16'h0004};
    vecs[1] = '{4'd2,  16'h0064, 16'h0064};
    vecs[2] = '{4'd3,  16'hFFFF, 16'hFFFF};
    vecs[3] = '{4'd3,  16'h0028, 16'h0028};
    vecs[4] = '{4'd5,  16'h1234, 16'h0000};
    vecs[5] = '{4'd15, 16'hFFFF, 16'h0000};
    vecs[6] = '{4'd0,  16'hFF4A, 16'h004A};
    vecs[7] = '{4'd0,  16'hFFA0, 16'h0000};
    vecs[8] = '{4'd0,  16'h0000, 16'h0000};

    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    wb.i_wb_adr = '0;   wb.i_wb_data = '0;

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_pwm", o_pwm, 0);
    chk("rst_ack", wb.o_wb_ack, 0);
    chk("rst_rdata", wb.o_wb_data, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    for (int a = 0; a < 16; a++) begin
      bus(1'b0, 4'(a), 16'h0, rd);
      chk("rst_reg", rd, 0);
    end
    wr(4'd2, 16'd100);
    bus(1'b0, 4'd2, 16'h0, rd);
    chk("period_readback", rd, 100);

    // held strobe: ack toggles every cycle
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_adr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      ackpat[i] = wb.o_wb_ack;
    end
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    chk("held_stb_ack", ackpat, 4'b0101);

    // register table
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].adr, vecs[i].wd);
      bus(1'b0, vecs[i].adr, 16'h0, rd);
      chk($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
    end

    // PWM from dc register: 160 high / 240 low
    cfg(4, 100, 40, 16'h0016);
    pwm_window("pwm_dc40", 4, 100, 40, 1'b1, 800);

    // external duty, latched value survives valid dropping
    i_DC = 16'd50; i_DC_valid = 1'b1;
    @(posedge i_clk); #1;
    i_DC_valid = 1'b0; i_DC = 16'd7;
    cfg(4, 100, 40, 16'h0056);
    pwm_window("pwm_ext50", 4, 100, 50, 1'b1, 800);

    // boundaries
    cfg(4, 100, 0, 16'h0016);
    pwm_window("pwm_dc0", 4, 100, 0, 1'b1, 400);
    cfg(4, 100, 100, 16'h0016);
    pwm_window("pwm_dc_full", 4, 100, 100, 1'b1, 400);
    cfg(4, 100, 40, 16'h0006);
    pwm_window("pwm_out_dis", 4, 100, 40, 1'b0, 400);

    // randomized PWM configurations, including divisor 0 and period 0
    for (int r = 0; r < 6; r++) begin
      int dv, pr, dt;
      bit oe;
      dv = $urandom_range(0, 5);
      pr = $urandom_range(0, 20);
      dt = $urandom_range(0, 23);
      oe = ($urandom_range(0, 7) != 0);
      cfg(dv, pr, dt, oe ? 16'h0016 : 16'h0006);
      pwm_window($sformatf("pwm_rand%0d", r), dv, pr, dt, oe, 300);
    end

    // one-shot timer: flag after 400 cycles, then self-disables
    cfg(4, 100, 40, 16'h0054);
    bad = 0;
    for (int k = 0; k < 420; k++) begin
      @(posedge i_clk); #1;
      if (o_pwm !== (k >= 400)) bad++;
    end
    chk("timer_oneshot", bad, 0);
    bus(1'b0, 4'd0, 16'h0, rd);
    chk("timer_ctrl", rd, 16'h0070);
    wr(4'd0, 16'h0050);
    chk("timer_clear", o_pwm, 0);
    repeat (20) @(posedge i_clk);
    #1;
    chk("timer_stays_clear", o_pwm, 0);

    // external tick source: 20 high / 20 low
    ext_run = 1'b1;
    cfg(1, 10, 5, 16'h0017);
    repeat (60) @(posedge i_clk);
    #1;
    prev = o_pwm; last = -1; ntr = 0; bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge i_clk); #1;
      if (o_pwm !== prev) begin
        if (last >= 0 && (k - last) != 20) bad++;
        last = k; ntr++; prev = o_pwm;
      end
    end
    ext_run = 1'b0;
    chk("extclk_intervals", bad, 0);
    chk("extclk_edges", (ntr >= 16), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
